// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory port and IF/ID register bundle of the fetch stage
interface fetch_stage_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] if_id_instr;
    logic [ADDR_WIDTH-1:0]  if_id_pc;
    logic                   if_id_valid;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output if_id_instr,
        output if_id_pc,
        output if_id_valid
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - pipeline fetch stage: PC, IF/ID register, hazard decode and stall/flush counters
module fetch_stage #(
    parameter int                         ADDR_WIDTH   = 8,
    parameter int                         INSTR_WIDTH  = 16,
    parameter int                         HAZARD_WIDTH = 3,
    parameter int                         CNT_WIDTH    = 16,
    parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR    = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [HAZARD_WIDTH-1:0] hazard,
    input  logic [ADDR_WIDTH-1:0]   branch_target,
    input  logic [ADDR_WIDTH-1:0]   jump_target,
    input  logic                    clr_counts,
    fetch_stage_if.master           bus,
    output logic                    halted,
    output logic [CNT_WIDTH-1:0]    stall_count,
    output logic [CNT_WIDTH-1:0]    flush_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [HAZARD_WIDTH-1:0] HZ_STALL   = HAZARD_WIDTH'(1);
    localparam logic [HAZARD_WIDTH-1:0] HZ_BRANCH0 = HAZARD_WIDTH'(2);
    localparam logic [HAZARD_WIDTH-1:0] HZ_BRANCH1 = HAZARD_WIDTH'(3);
    localparam logic [HAZARD_WIDTH-1:0] HZ_JUMP    = HAZARD_WIDTH'(4);
    localparam logic [HAZARD_WIDTH-1:0] HZ_HALT    = HAZARD_WIDTH'(5);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  ifpc_q, ifpc_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
    logic                   stall_inc;
    logic                   flush_inc;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifpc_d    = ifpc_q;
        valid_d   = valid_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                case (hazard)
                    HZ_STALL: begin
                        stall_inc = 1'b1;
                    end
                    HZ_BRANCH0, HZ_BRANCH1, HZ_JUMP, HZ_HALT: begin
                        // Every redirect and halt squashes the fetched word into a bubble
                        instr_d = NOP_INSTR;
                        ifpc_d  = pc_q;
                        valid_d = 1'b0;
                        if (hazard == HZ_HALT) begin
                            state_d = ST_HALTED;
                        end else begin
                            flush_inc = 1'b1;
                            pc_d      = (hazard == HZ_JUMP) ? jump_target : branch_target;
                        end
                    end
                    default: begin
                        pc_d    = pc_q + 1'b1;
                        instr_d = bus.imem_rdata;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear dominates; increments stop at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_counts) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            instr_q     <= NOP_INSTR;
            ifpc_q      <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            ifpc_q      <= ifpc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ifpc_q;
    assign bus.if_id_valid = valid_q;
    assign halted          = (state_q == ST_HALTED);
    assign stall_count     = stall_cnt_q;
    assign flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with a behavioural reference model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  hazard = 3'd0;
    logic [7:0]  branch_target = 8'd0;
    logic [7:0]  jump_target = 8'd0;
    logic        clr_counts = 1'b0;
    logic        halted;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) bus ();

    // Instruction memory: word at address a holds 0x1000 + a
    assign bus.imem_rdata = 16'h1000 + {8'h00, bus.imem_addr};

    fetch_stage #(
        .ADDR_WIDTH(8), .INSTR_WIDTH(16), .HAZARD_WIDTH(3), .CNT_WIDTH(16), .NOP_INSTR(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hazard(hazard),
        .branch_target(branch_target), .jump_target(jump_target),
        .clr_counts(clr_counts), .bus(bus.master), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Reference model: mode 0 = idle, 1 = running, 2 = halted
    int m_mode = 0, m_pc = 0, m_instr = 0, m_ifpc = 0, m_valid = 0, m_stall = 0, m_flush = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0; m_stall = 0; m_flush = 0;
        end else begin
            int h;
            bit did_stall, did_flush;
            h = int'(hazard);
            did_stall = 0;
            did_flush = 0;
            if (m_mode != 1) begin
                if (start) m_mode = 1;
            end else begin
                if (h >= 6) h = 0;
                if (h == 0) begin
                    m_ifpc = m_pc; m_instr = 'h1000 + m_pc; m_valid = 1;
                    m_pc = (m_pc + 1) % 256;
                end else if (h == 1) begin
                    did_stall = 1;
                end else begin
                    m_ifpc = m_pc; m_instr = 0; m_valid = 0;
                    if (h == 5) m_mode = 2;
                    else begin
                        did_flush = 1;
                        m_pc = (h == 4) ? int'(jump_target) : int'(branch_target);
                    end
                end
            end
            if (clr_counts) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (did_stall && m_stall < 65535) m_stall = m_stall + 1;
                if (did_flush && m_flush < 65535) m_flush = m_flush + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.imem_addr",   int'(bus.imem_addr),   m_pc);
        chk("m.if_id_instr", int'(bus.if_id_instr), m_instr);
        chk("m.if_id_pc",    int'(bus.if_id_pc),    m_ifpc);
        chk("m.if_id_valid", int'(bus.if_id_valid), m_valid);
        chk("m.halted",      int'(halted),          (m_mode == 2) ? 1 : 0);
        chk("m.stall_count", int'(stall_count),     m_stall);
        chk("m.flush_count", int'(flush_count),     m_flush);
    end

    task automatic cyc(input logic s, input logic [2:0] h, input logic [7:0] b = 8'd0,
                       input logic [7:0] j = 8'd0, input logic c = 1'b0);
        start = s; hazard = h; branch_target = b; jump_target = j; clr_counts = c;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk("reset.imem_addr", int'(bus.imem_addr), 0);
        chk("reset.valid", int'(bus.if_id_valid), 0);
        chk("reset.instr", int'(bus.if_id_instr), 0);
        chk("reset.halted", int'(halted), 0);
        chk("reset.stall", int'(stall_count), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0);
        chk("idle.pc", int'(bus.imem_addr), 0);
        chk("idle.valid", int'(bus.if_id_valid), 0);

        cyc(1'b1, 3'd0);
        chk("start.pc", int'(bus.imem_addr), 0);
        for (int i = 1; i <= 4; i++) begin
            cyc((i == 4), 3'd0);
            chk("run.pc", int'(bus.imem_addr), i);
        end
        chk("run.instr", int'(bus.if_id_instr), 'h1003);
        chk("run.ifpc", int'(bus.if_id_pc), 3);
        chk("run.valid", int'(bus.if_id_valid), 1);

        cyc(1'b0, 3'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'd1);
        chk("stall.pc", int'(bus.imem_addr), 5);
        chk("stall.instr", int'(bus.if_id_instr), 'h1004);
        chk("stall.count", int'(stall_count), 3);
        cyc(1'b0, 3'd0);
        chk("unstall.pc", int'(bus.imem_addr), 6);

        cyc(1'b0, 3'd0);
        cyc(1'b0, 3'd2, 8'h20, 8'h00);
        chk("branch.pc", int'(bus.imem_addr), 'h20);
        chk("branch.valid", int'(bus.if_id_valid), 0);
        chk("branch.instr", int'(bus.if_id_instr), 0);
        chk("branch.ifpc", int'(bus.if_id_pc), 7);
        chk("branch.flush", int'(flush_count), 1);
        cyc(1'b0, 3'd4, 8'h00, 8'h40);
        chk("jump.pc", int'(bus.imem_addr), 'h40);
        chk("jump.flush", int'(flush_count), 2);
        cyc(1'b0, 3'd3, 8'h30, 8'h00);
        chk("branch3.pc", int'(bus.imem_addr), 'h30);
        cyc(1'b0, 3'd6);
        chk("code6.pc", int'(bus.imem_addr), 'h31);
        chk("code6.instr", int'(bus.if_id_instr), 'h1030);

        cyc(1'b0, 3'd4, 8'h00, 8'hFF);
        cyc(1'b0, 3'd7);
        chk("wrap.pc", int'(bus.imem_addr), 0);
        chk("wrap.ifpc", int'(bus.if_id_pc), 'hFF);
        chk("wrap.instr", int'(bus.if_id_instr), 'h10FF);

        cyc(1'b0, 3'd4, 8'h00, 8'h09);
        cyc(1'b0, 3'd5);
        chk("halt.halted", int'(halted), 1);
        chk("halt.pc", int'(bus.imem_addr), 9);
        chk("halt.flush", int'(flush_count), 5);
        cyc(1'b0, 3'd0); cyc(1'b0, 3'd1); cyc(1'b0, 3'd2, 8'h77); cyc(1'b0, 3'd4, 8'h00, 8'h66);
        chk("halted.pc", int'(bus.imem_addr), 9);
        chk("halted.stall", int'(stall_count), 3);
        cyc(1'b1, 3'd2, 8'h55);
        chk("resume.halted", int'(halted), 0);
        chk("resume.pc", int'(bus.imem_addr), 9);
        cyc(1'b0, 3'd0);
        chk("resume.fetch_pc", int'(bus.if_id_pc), 9);
        chk("resume.fetch_instr", int'(bus.if_id_instr), 'h1009);

        cyc(1'b0, 3'd1, 8'h00, 8'h00, 1'b1);
        chk("clr.stall", int'(stall_count), 0);
        chk("clr.flush", int'(flush_count), 0);

        for (int i = 0; i < 65535; i++) cyc(1'b0, 3'd1);
        chk("sat.reach", int'(stall_count), 'hFFFF);
        cyc(1'b0, 3'd1);
        chk("sat.hold", int'(stall_count), 'hFFFF);
        cyc(1'b0, 3'd1, 8'h00, 8'h00, 1'b1);
        chk("sat.clr", int'(stall_count), 0);

        cyc(1'b0, 3'd2, 8'h50);
        cyc(1'b0, 3'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async.pc", int'(bus.imem_addr), 0);
        chk("async.valid", int'(bus.if_id_valid), 0);
        chk("async.ifpc", int'(bus.if_id_pc), 0);
        chk("async.flush", int'(flush_count), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cyc(1'b0, 3'd0); cyc(1'b0, 3'd0);
        chk("post_reset.idle_pc", int'(bus.imem_addr), 0);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
